// File: rtl/serial_subtractor.sv
// Multi-cycle Diff = A - B - Bin, BITS_PER_CYCLE bits per clock, LSB chunk first; optional Ovf when SERIAL_SUB_OVF_EN is defined.
// Latency: start sampled at edge 0, done pulses after edge STEPS; busy high after edges 0..STEPS-1.
// Backpressure: none; start is ignored while busy and accepted in IDLE or DONE (back-to-back).
module serial_subtractor #(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             Ovf
`endif
);

  localparam int BPC   = BITS_PER_CYCLE;
  localparam int STEPS = WIDTH / BPC;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  generate
    if ((WIDTH < 1) || (BPC < 1) || ((WIDTH % BPC) != 0)) begin : g_bad_cfg
      $error("serial_subtractor: BITS_PER_CYCLE must divide WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, res_q, res_nxt;
  logic             brw_q;
  logic [CW-1:0]    cnt_q;
  logic [BPC-1:0]   chunk_d;
  logic             chunk_bo;
  logic             bw;
  logic             accept, last;

  // Borrow ripples through the BPC full-subtractor bits of the current chunk.
  always_comb begin
    bw      = brw_q;
    chunk_d = '0;
    for (int i = 0; i < BPC; i++) begin
      chunk_d[i] = a_q[i] ^ b_q[i] ^ bw;
      bw         = (~a_q[i] & b_q[i]) | (~(a_q[i] ^ b_q[i]) & bw);
    end
    chunk_bo = bw;
    res_nxt  = (res_q >> BPC) | (WIDTH'(chunk_d) << (WIDTH - BPC));
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    last    = 1'b0;
    case (state_q)
      IDLE: begin
        accept = start;
        if (start) state_d = RUN;
      end
      RUN: begin
        last = (cnt_q == CW'(STEPS - 1));
        if (last) state_d = DONE;
      end
      DONE: begin
        accept  = start;
        state_d = start ? RUN : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef SERIAL_SUB_OVF_EN
  logic a_msb_q, b_msb_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      brw_q   <= 1'b0;
      cnt_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      Diff    <= '0;
      Bout    <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      Ovf     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      done    <= last;
      if (accept) begin
        a_q     <= A;
        b_q     <= B;
        brw_q   <= Bin;
        res_q   <= '0;
        cnt_q   <= '0;
        busy    <= 1'b1;
`ifdef SERIAL_SUB_OVF_EN
        a_msb_q <= A[WIDTH-1];
        b_msb_q <= B[WIDTH-1];
`endif
      end else if (state_q == RUN) begin
        a_q   <= a_q >> BPC;
        b_q   <= b_q >> BPC;
        brw_q <= chunk_bo;
        res_q <= res_nxt;
        cnt_q <= cnt_q + CW'(1);
        if (last) begin
          Diff <= res_nxt;
          Bout <= chunk_bo;
          busy <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
          Ovf  <= (a_msb_q != b_msb_q) && (res_nxt[WIDTH-1] != a_msb_q);
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: an 8x1 and an 8x4 instance, directed vectors.
module tb_serial_subtractor;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bi;
    logic [7:0] d;
    logic       bo;
    logic       ov;
  } vec_t;

  typedef struct {
    logic [7:0] d;
    logic       bo;
    logic       ov;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       s1 = 1'b0, s4 = 1'b0;
  logic [7:0] a1 = '0, b1 = '0, a4 = '0, b4 = '0;
  logic       bi1 = 1'b0, bi4 = 1'b0;
  logic       busy1, done1, bo1, busy4, done4, bo4;
  logic [7:0] d1, d4;
`ifdef SERIAL_SUB_OVF_EN
  logic       ov1, ov4;
`endif

  exp_t q1[$];
  exp_t q4[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  serial_subtractor #(.WIDTH(8), .BITS_PER_CYCLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(s1), .A(a1), .B(b1), .Bin(bi1),
    .busy(busy1), .done(done1), .Diff(d1), .Bout(bo1)
`ifdef SERIAL_SUB_OVF_EN
    , .Ovf(ov1)
`endif
  );

  serial_subtractor #(.WIDTH(8), .BITS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(s4), .A(a4), .B(b4), .Bin(bi4),
    .busy(busy4), .done(done4), .Diff(d4), .Bout(bo4)
`ifdef SERIAL_SUB_OVF_EN
    , .Ovf(ov4)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (done1 === 1'b1) begin
      if (q1.size() == 0) begin
        total++; bad++;
        $display("FAIL done1_unexpected: got done=1 expected none (cycle %0d)", cyc);
      end else begin
        e = q1.pop_front();
        chk("diff1", {24'd0, d1}, {24'd0, e.d});
        chk("bout1", {31'd0, bo1}, {31'd0, e.bo});
        chk("lat1", cyc, e.cyc);
`ifdef SERIAL_SUB_OVF_EN
        chk("ovf1", {31'd0, ov1}, {31'd0, e.ov});
`endif
      end
    end
    if (done4 === 1'b1) begin
      if (q4.size() == 0) begin
        total++; bad++;
        $display("FAIL done4_unexpected: got done=1 expected none (cycle %0d)", cyc);
      end else begin
        e = q4.pop_front();
        chk("diff4", {24'd0, d4}, {24'd0, e.d});
        chk("bout4", {31'd0, bo4}, {31'd0, e.bo});
        chk("lat4", cyc, e.cyc);
`ifdef SERIAL_SUB_OVF_EN
        chk("ovf4", {31'd0, ov4}, {31'd0, e.ov});
`endif
      end
    end
  end

  task automatic start_op(input bit w4, input vec_t v, input bit push, input bit hold,
                          output int s);
    exp_t e;
    @(negedge clk);
    if (w4) begin a4 = v.a; b4 = v.b; bi4 = v.bi; s4 = 1'b1; end
    else    begin a1 = v.a; b1 = v.b; bi1 = v.bi; s1 = 1'b1; end
    @(posedge clk);
    #1;
    s = cyc;
    if (push) begin
      e.d = v.d; e.bo = v.bo; e.ov = v.ov; e.cyc = s + (w4 ? 2 : 8);
      if (w4) q4.push_back(e); else q1.push_back(e);
    end
    @(negedge clk);
    if (!hold) begin
      if (w4) s4 = 1'b0; else s1 = 1'b0;
    end
  endtask

  task automatic run_op(input bit w4, input vec_t v);
    int s;
    int steps;
    steps = w4 ? 2 : 8;
    start_op(w4, v, 1'b1, 1'b0, s);
    for (int k = 0; k < steps; k++) begin
      chk(w4 ? "busy4_run" : "busy1_run", {31'd0, w4 ? busy4 : busy1}, 32'd1);
      if (k < steps - 1) @(negedge clk);
    end
    @(negedge clk);
    chk(w4 ? "busy4_done" : "busy1_done", {31'd0, w4 ? busy4 : busy1}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk(w4 ? "diff4_hold" : "diff1_hold", {24'd0, w4 ? d4 : d1}, {24'd0, v.d});
  endtask

  vec_t v1[7];
  vec_t v4[3];

  initial begin
    int s;
    vec_t x, y;
    v1 = '{'{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0},
           '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0},
           '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0},
           '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1},
           '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1},
           '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0},
           '{8'hAA, 8'h55, 1'b0, 8'h55, 1'b0, 1'b1}};
    v4 = '{'{8'h3C, 8'h1D, 1'b1, 8'h1E, 1'b0, 1'b0},
           '{8'h10, 8'h20, 1'b0, 8'hF0, 1'b1, 1'b0},
           '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b0, 1'b1}};

    #1 rst_n = 1'b0;
    #2;
    chk("rst_busy1", {31'd0, busy1}, 32'd0);
    chk("rst_done1", {31'd0, done1}, 32'd0);
    chk("rst_diff1", {24'd0, d1}, 32'd0);
    chk("rst_bout1", {31'd0, bo1}, 32'd0);
    chk("rst_busy4", {31'd0, busy4}, 32'd0);
    chk("rst_diff4", {24'd0, d4}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    foreach (v1[i]) run_op(1'b0, v1[i]);
    foreach (v4[i]) run_op(1'b1, v4[i]);

    // start re-pulsed mid-run with other operands must be ignored
    start_op(1'b0, v1[0], 1'b1, 1'b0, s);
    @(negedge clk);
    @(negedge clk);
    a1 = 8'hFF; b1 = 8'h00; bi1 = 1'b0; s1 = 1'b1;
    @(negedge clk);
    s1 = 1'b0;
    repeat (9) @(negedge clk);

    // start held high through DONE: second op begins with no IDLE gap
    x = '{8'h12, 8'h34, 1'b0, 8'hDE, 1'b1, 1'b0};
    y = '{8'h34, 8'h12, 1'b1, 8'h21, 1'b0, 1'b0};
    start_op(1'b0, x, 1'b1, 1'b1, s);
    a1 = y.a; b1 = y.b; bi1 = y.bi;
    repeat (9) @(posedge clk);
    #1;
    chk("b2b_busy", {31'd0, busy1}, 32'd1);
    begin
      exp_t e;
      e.d = y.d; e.bo = y.bo; e.ov = y.ov; e.cyc = s + 17;
      q1.push_back(e);
    end
    @(negedge clk);
    s1 = 1'b0;
    repeat (10) @(negedge clk);

    // asynchronous reset mid-run aborts without a done pulse
    start_op(1'b0, '{8'h09, 8'h01, 1'b0, 8'h08, 1'b0, 1'b0}, 1'b0, 1'b0, s);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy1}, 32'd0);
    chk("abort_done", {31'd0, done1}, 32'd0);
    chk("abort_diff", {24'd0, d1}, 32'd0);
    chk("abort_bout", {31'd0, bo1}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("abort_idle_busy", {31'd0, busy1}, 32'd0);

    chk("q1_drained", q1.size(), 32'd0);
    chk("q4_drained", q4.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
